// File: rtl/rr_arb_pkg.sv
// Shared types, default parameters and the wrap-around winner search
// used by the round-robin delayed-grant arbiter.
package rr_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, GRANT, GAP} arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_GNT_DELAY = 2;
  localparam int DEF_MAX_HOLD  = 8;

  // Requests above N_REQ are zero-extended, so a wrap at 16 matches a wrap at N_REQ.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] ptr);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int i = 15; i >= 0; i--) begin
      idx = ptr + 4'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational wrap-around first-one finder: the first set request at or
// above the pointer, wrapping from N_REQ-1 back to 0.
module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_any
);

  localparam int IW = $clog2(N_REQ);

  assign o_idx = IW'(rr_pick(16'(i_req), 4'(i_ptr)));
  assign o_any = |i_req;

endmodule

// File: rtl/rr_delay_arbiter.sv
// Round-robin arbiter whose grant appears exactly GNT_DELAY sampled cycles
// after the winning request, with bounded hold, abort and a one-cycle gap.
module rr_delay_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int GNT_DELAY = DEF_GNT_DELAY,
  parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     abort,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int DW = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;

  arb_state_t        r_state;
  logic [IW-1:0]     r_rr_ptr;
  logic [DW-1:0]     r_dly_cnt;
  logic [HW-1:0]     r_hold_cnt;
  logic [N_REQ-1:0]  r_gnt;
  logic              r_gnt_valid;
  logic [IW-1:0]     r_gnt_id;
  logic              r_abort;
  logic              r_timeout;

  logic [IW-1:0]     w_pick;
  logic              w_any;
  logic              w_owner_req;
  logic              w_hold_done;

  rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  assign w_owner_req = req[r_gnt_id];
  assign w_hold_done = (r_hold_cnt == HW'(MAX_HOLD - 1));

  // Only the latched winner's request matters once arbitration has started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_dly_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_abort     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_abort   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt_id <= w_pick;
            if (GNT_DELAY == 1) begin
              r_gnt       <= N_REQ'(1) << w_pick;
              r_gnt_valid <= 1'b1;
              r_hold_cnt  <= '0;
              r_state     <= GRANT;
            end else begin
              r_dly_cnt <= DW'(GNT_DELAY - 2);
              r_state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!w_owner_req) begin
            r_abort <= 1'b1;
            r_state <= IDLE;
          end else if (r_dly_cnt == '0) begin
            r_gnt       <= N_REQ'(1) << r_gnt_id;
            r_gnt_valid <= 1'b1;
            r_hold_cnt  <= '0;
            r_state     <= GRANT;
          end else begin
            r_dly_cnt <= r_dly_cnt - DW'(1);
          end
        end
        GRANT: begin
          r_hold_cnt <= r_hold_cnt + HW'(1);
          if (!w_owner_req || w_hold_done) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= w_owner_req;
            r_rr_ptr    <= (r_gnt_id == IW'(N_REQ - 1)) ? '0 : r_gnt_id + IW'(1);
            r_state     <= GAP;
          end
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_id    = r_gnt_id;
  assign abort     = r_abort;
  assign timeout   = r_timeout;

endmodule
